fifo_rd_ptr_ctrl: RTL
=====================

Name: fifo_rd_ptr_ctrl

Overview:
Read-side pointer and status controller for the asynchronous FIFO, all in the read clock domain. It owns the binary/Gray read pointer and drives the memory read address. It synchronises the write pointer (Gray) arriving from the write domain and produces the registered empty, almost-empty, fill-level and underflow indications. It is the counterpart of the write-side full logic: the write side exports wptr_gray, and this block exports rptr_gray back for the write-domain full comparison.

Parameters:
ADDR, 5, memory address width; pointers are ADDR+1 bits (MSB is the wrap bit); depth = 2^ADDR
AE_LEVEL, 2, almost-empty threshold; ralmost_empty asserts when level <= AE_LEVEL (legal range 0 .. 2^ADDR-1)

Ports:
rclk  input  1  read-domain clock; all state updates on its rising edge
rrst  input  1  asynchronous, active-high reset
rinc  input  1  read request; a read is accepted only when rinc=1 and rempty=0
wptr_gray  input  ADDR+1  write pointer (Gray) from the write domain; asynchronous to rclk
raddr  output  ADDR  memory read address = rptr_bin[ADDR-1:0]
rptr_gray  output  ADDR+1  registered Gray read pointer, exported to the write domain
rempty  output  1  registered empty flag
ralmost_empty  output  1  registered, level <= AE_LEVEL
rlevel  output  ADDR+1  registered fill level as seen by the read domain, 0 .. 2^ADDR
rd_err  output  1  one-cycle pulse, registered: rinc=1 while rempty=1

Behaviour:
- Reset (rrst=1, async): rptr_bin=0, rptr_gray=0, both sync stages=0, rempty=1, ralmost_empty=1, rlevel=0, rd_err=0, raddr=0. All registers stay in reset while rrst is high.
- Synchroniser: wq1 <= wptr_gray; wq2 <= wq1. Only wq2 is used downstream. The synchroniser carries Gray code only, never binary.
- wq2_bin = gray2bin(wq2), combinational.
- Accept: rd_fire = rinc & ~rempty. rptr_bin_next = rptr_bin + rd_fire, modulo 2^(ADDR+1): wraps from 2^(ADDR+1)-1 to 0 and toggles the wrap bit each pass through the memory.
- rptr_gray_next = rptr_bin_next ^ (rptr_bin_next >> 1). rptr_bin and rptr_gray are registered together, so rptr_gray changes by exactly one bit per accepted read.
- rempty <= (rptr_gray_next == wq2). Full Gray equality, including the wrap bit.
- level_next = (wq2_bin - rptr_bin_next) mod 2^(ADDR+1). rlevel <= level_next. ralmost_empty <= (level_next <= AE_LEVEL).
- rd_err <= rinc & rempty. On underflow the pointer holds; there are no other side effects.
- Latency: if wptr_gray is stable before rclk edge N, wq2 updates at edge N+1 and rempty/rlevel reflect it at edge N+2. A read accepted at edge N updates raddr/rptr_gray at N and rempty/rlevel at the same edge N.
- Simultaneous read and write-pointer advance: both terms enter level_next in the same cycle; no ordering priority applies.
- The last entry being read while no write arrives makes rempty=1 at that same edge, so no extra read is accepted.
- rempty is pessimistic: it may deassert late, never early. A level of 2^ADDR (full) is representable; ralmost_empty=0 in that case unless AE_LEVEL >= 2^ADDR.
- A mid-operation rrst returns all state to reset values immediately. Re-aligning the write side is the integrator's responsibility (both sides are reset together).

Decomposition:
- Shared package fifo_pkg: functions bin2gray and gray2bin (width ADDR+1), and a localparam DEPTH = 2^ADDR. The write-side controller uses the same package.
- Sub-module ptr_sync: parameter W, two-flop synchroniser with async active-high reset to 0. It is reused by the write side for rptr_gray.

Test Plan:
- Reset: assert rrst mid-stream with rptr_bin=5 -> immediately raddr=0, rptr_gray=0, rempty=1, rlevel=0, ralmost_empty=1.
- Sync latency (ADDR=3): wptr_gray steps 0->1 just before edge N -> rempty=1 at N+1, rempty=0 and rlevel=1 at N+2.
- Drain (ADDR=3, AE_LEVEL=2): wptr_gray=bin2gray(8), i.e. full, with rinc=1 continuous -> rlevel 8,7,...,1,0; ralmost_empty rises when rlevel=2; rempty=1 exactly after 8 reads; raddr sequence 0..7.
- Wrap (ADDR=3): perform 20 writes and 20 reads interleaved -> rptr_bin passes 15->0; rptr_gray changes one bit per read; final rempty=1, rlevel=0, raddr=4.
- Underflow: rempty=1, rinc=1 for 3 cycles -> rd_err=1 for 3 cycles, rptr_gray unchanged, rlevel stays 0.
- Concurrent (ADDR=3): rlevel=3, one read accepted in the same cycle wq2 advances by 1 -> rlevel stays 3, rempty=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and default geometry.
package fifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;
    localparam int unsigned FIFO_ADDR = 5;
    localparam int unsigned DEPTH     = 1 << FIFO_ADDR;

    // Width-independent: callers zero-extend their pointer into 32 bits
    // and truncate the result back, so one function serves any ADDR.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_MAX_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
module ptr_sync
    import fifo_pkg::*;
#(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q1;
    logic [W-1:0] r_q2;

    // Metastability filter: only the second stage is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer, empty/almost-empty/level and underflow logic of the async FIFO.
module fifo_rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR     = 5,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic            rclk,
    input  logic            rrst,
    input  logic            rinc,
    input  logic [ADDR:0]   wptr_gray,
    output logic [ADDR-1:0] raddr,
    output logic [ADDR:0]   rptr_gray,
    output logic            rempty,
    output logic            ralmost_empty,
    output logic [ADDR:0]   rlevel,
    output logic            rd_err
);

    localparam int unsigned PW = ADDR + 1;

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_empty;
    logic          r_ae;
    logic [PW-1:0] r_level;
    logic          r_err;

    logic [PW-1:0] w_wq2;
    logic [PW-1:0] w_wq2_bin;
    logic          w_rd_fire;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_level_next;

    ptr_sync #(.W(PW)) u_wptr_sync (
        .clk (rclk),
        .rst (rrst),
        .i_d (wptr_gray),
        .o_q (w_wq2)
    );

    // Next-pointer and level arithmetic; wrap is implicit in the PW-bit width.
    always_comb begin
        w_wq2_bin    = PW'(gray2bin(PTR_MAX_W'(w_wq2)));
        w_rd_fire    = rinc & ~r_empty;
        w_bin_next   = r_bin + PW'(w_rd_fire);
        w_gray_next  = PW'(bin2gray(PTR_MAX_W'(w_bin_next)));
        w_level_next = w_wq2_bin - w_bin_next;
    end

    // Pointer and status registers; flags use the post-read pointer so the
    // last read sets empty on the same edge.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_empty <= 1'b1;
            r_ae    <= 1'b1;
            r_level <= '0;
            r_err   <= 1'b0;
        end else begin
            r_bin   <= w_bin_next;
            r_gray  <= w_gray_next;
            r_empty <= (w_gray_next == w_wq2);
            r_ae    <= (PTR_MAX_W'(w_level_next) <= PTR_MAX_W'(AE_LEVEL));
            r_level <= w_level_next;
            r_err   <= rinc & r_empty;
        end
    end

    assign raddr         = r_bin[ADDR-1:0];
    assign rptr_gray     = r_gray;
    assign rempty        = r_empty;
    assign ralmost_empty = r_ae;
    assign rlevel        = r_level;
    assign rd_err        = r_err;

endmodule
